instr_prefetch: RTL and testbench

Instruction prefetch stage sitting directly upstream of the single-cycle datapath. Fetches 16-bit instructions from instruction memory over a req/ack handshake with variable latency, buffers them with their PCs in a small FIFO, and presents them to the datapath via a valid/ready handshake. A redirect from the datapath (taken branch, PC write) flushes the buffer and restarts fetching at the new PC.

---
 rtl/cpu_fetch_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 54 +++++
 rtl/instr_prefetch.sv | 115 +++++++++++
 tb/tb_instr_prefetch.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_fetch_pkg.sv
// Shared types for the instruction prefetch stage: FSM states, FIFO entry, default PC step.
package cpu_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [15:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  localparam logic [31:0] DEFAULT_PC_STEP = 32'd2;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries; flush overrides push and pop.
module fetch_fifo
  import cpu_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  fetch_entry_t               wdata,
  input  logic                       pop,
  input  logic                       flush,
  output fetch_entry_t               rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  // Head is read straight from storage so outputs never see the memory bus.
  assign rdata = mem[rd_ptr];
  assign count = cnt;
  assign full  = (cnt == DEPTH_C);
  assign empty = (cnt == '0);

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetch: req/ack fetch into a small FIFO, valid/ready to the datapath, redirect flush.
// Optional perf counters with `define PREFETCH_PERF_EN.
//
// state | meaning
// IDLE  | no request outstanding
// WAIT  | request outstanding, result will be kept
// DROP  | request outstanding, result will be discarded (redirected meanwhile)
module instr_prefetch
  import cpu_fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] PC_STEP  = DEFAULT_PC_STEP,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic        instr_valid,
  output logic [15:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
`ifdef PREFETCH_PERF_EN
  ,
  output logic [31:0] perf_fetches,
  output logic [31:0] perf_flushes
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_t  state, state_nxt;
  logic [31:0]   fetch_pc, fetch_pc_nxt;
  logic          push, pop, flush;
  logic [CW-1:0] count, cnt_after;
  logic          full, empty;
  fetch_entry_t  head, wentry;

  assign wentry = '{instr: imem_rdata, pc: fetch_pc};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (wentry),
    .pop   (pop),
    .flush (flush),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    push         = 1'b0;
    flush        = 1'b0;
    pop          = !empty && instr_ready && !redirect;
    cnt_after    = count + CW'(1) - CW'(pop);
    unique case (state)
      IDLE: if (!full) state_nxt = WAIT;
      WAIT: begin
        if (imem_ack) begin
          push         = 1'b1;
          fetch_pc_nxt = fetch_pc + PC_STEP;
          state_nxt    = (cnt_after < DEPTH_C) ? WAIT : IDLE;
        end
      end
      DROP: if (imem_ack) state_nxt = WAIT;
      default: state_nxt = IDLE;
    endcase
    // Redirect wins: an ack completing now frees the bus, otherwise wait out the stale one.
    if (redirect) begin
      flush        = 1'b1;
      push         = 1'b0;
      fetch_pc_nxt = redirect_pc;
      state_nxt    = (state == IDLE || imem_ack) ? WAIT : DROP;
    end
  end

  assign imem_req    = (state == WAIT) || (state == DROP);
  assign imem_addr   = fetch_pc;
  assign instr_valid = !empty;
  assign instr       = head.instr;
  assign instr_pc    = head.pc;

`ifdef PREFETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetches <= '0;
      perf_flushes <= '0;
    end else begin
      if (push)     perf_fetches <= perf_fetches + 32'd1;
      if (redirect) perf_flushes <= perf_flushes + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_prefetch.sv
// Self-checking bench for instr_prefetch: vector table, corner sequences, random run against a queue model.
module tb_instr_prefetch;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic [15:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
`ifdef PREFETCH_PERF_EN
  logic [31:0] perf_fetches;
  logic [31:0] perf_flushes;
`endif

  instr_prefetch #(.DEPTH(DEPTH), .PC_STEP(32'd2), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
`ifdef PREFETCH_PERF_EN
    ,
    .perf_fetches(perf_fetches),
    .perf_flushes(perf_flushes)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [31:0] a);
    return a[16:1] ^ 16'hA5C3;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; imem_ack = 1'b0; redirect = 1'b0; instr_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evalid;
    logic [31:0] epc;
  } vec_t;

  typedef struct {
    logic [15:0] i;
    logic [31:0] p;
  } ent_t;

  vec_t tbl [9];
  ent_t m_q [$];
  logic [31:0] m_pc;
  int   m_out;      // 0 nothing pending, 1 pending and kept, 2 pending and discarded
  bit   mem_busy;
  int   mem_cnt;
  int   acks;

  initial begin
    // zero-wait memory, ready=1; redirect to 0x40 coincides with ack and pop
    tbl[0] = '{1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 32'h0};
    tbl[1] = '{1'b0, 32'h0,  1'b1, 32'h0,  1'b0, 32'h0};
    tbl[2] = '{1'b0, 32'h0,  1'b1, 32'h2,  1'b1, 32'h0};
    tbl[3] = '{1'b0, 32'h0,  1'b1, 32'h4,  1'b1, 32'h2};
    tbl[4] = '{1'b0, 32'h0,  1'b1, 32'h6,  1'b1, 32'h4};
    tbl[5] = '{1'b1, 32'h40, 1'b1, 32'h8,  1'b1, 32'h6};
    tbl[6] = '{1'b0, 32'h0,  1'b1, 32'h40, 1'b0, 32'h0};
    tbl[7] = '{1'b0, 32'h0,  1'b1, 32'h42, 1'b1, 32'h40};
    tbl[8] = '{1'b0, 32'h0,  1'b1, 32'h44, 1'b1, 32'h42};

    // ---- table phase ----
    do_reset();
    chk("rst_instr", {16'h0, instr}, 32'h0);
    chk("rst_pc", instr_pc, 32'h0);
`ifdef PREFETCH_PERF_EN
    chk("rst_perf_f", perf_fetches, 32'h0);
    chk("rst_perf_r", perf_flushes, 32'h0);
`endif
    for (int k = 0; k < 9; k++) begin
      instr_ready = 1'b1;
      redirect    = tbl[k].redir;
      redirect_pc = tbl[k].rpc;
      imem_ack    = imem_req;
      chk($sformatf("tbl%0d_req", k), {31'h0, imem_req}, {31'h0, tbl[k].ereq});
      chk($sformatf("tbl%0d_addr", k), imem_addr, tbl[k].eaddr);
      chk($sformatf("tbl%0d_valid", k), {31'h0, instr_valid}, {31'h0, tbl[k].evalid});
      if (tbl[k].evalid) begin
        chk($sformatf("tbl%0d_pc", k), instr_pc, tbl[k].epc);
        chk($sformatf("tbl%0d_instr", k), {16'h0, instr}, {16'h0, mem_word(tbl[k].epc)});
      end
      @(negedge clk);
    end
    redirect = 1'b0;

    // ---- FIFO fills with ready low ----
    do_reset();
    acks = 0;
    for (int k = 0; k < 12; k++) begin
      imem_ack = imem_req;
      if (imem_req) acks++;
      @(negedge clk);
    end
    imem_ack = 1'b0;
    chk("full_acks", acks, 4);
    chk("full_req", {31'h0, imem_req}, 32'h0);
    instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("drain_valid", {31'h0, instr_valid}, 32'h1);
      chk("drain_pc", instr_pc, 32'(2 * k));
      @(negedge clk);
    end

    // ---- redirect during a 3-cycle fetch ----
    do_reset();
    instr_ready = 1'b1;
    @(negedge clk);
    chk("lat_req", {31'h0, imem_req}, 32'h1);
    chk("lat_addr0", imem_addr, 32'h0);
    redirect = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    redirect = 1'b0;
    chk("lat_drop_req", {31'h0, imem_req}, 32'h1);
    chk("lat_drop_v1", {31'h0, instr_valid}, 32'h0);
    @(negedge clk);
    chk("lat_drop_v2", {31'h0, instr_valid}, 32'h0);
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("lat_new_req", {31'h0, imem_req}, 32'h1);
    chk("lat_new_addr", imem_addr, 32'h100);
    chk("lat_stale_v", {31'h0, instr_valid}, 32'h0);
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("lat_first_v", {31'h0, instr_valid}, 32'h1);
    chk("lat_first_pc", instr_pc, 32'h100);
    chk("lat_first_ins", {16'h0, instr}, {16'h0, mem_word(32'h100)});

    // ---- reset mid-transaction, late ack ignored ----
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    imem_ack = 1'b1;
    chk("late_req", {31'h0, imem_req}, 32'h0);
    @(negedge clk);
    imem_ack = 1'b0;
    chk("late_valid", {31'h0, instr_valid}, 32'h0);
    chk("late_req2", {31'h0, imem_req}, 32'h1);
    chk("late_addr", imem_addr, 32'h0);

    // ---- PC wrap ----
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE; imem_ack = imem_req;
    @(negedge clk);
    redirect = 1'b0;
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFE);
    imem_ack = 1'b1;
    @(negedge clk);
    chk("wrap_addr1", imem_addr, 32'h0);
    chk("wrap_pc0", instr_pc, 32'hFFFF_FFFE);
    @(negedge clk);
    imem_ack = 1'b0;
    chk("wrap_pc1", instr_pc, 32'h0);
    chk("wrap_addr2", imem_addr, 32'h2);

`ifdef PREFETCH_PERF_EN
    // ---- perf counters: 10 accepted fetches, 2 redirects ----
    do_reset();
    instr_ready = 1'b1;
    @(negedge clk);
    imem_ack = 1'b1;
    repeat (10) @(negedge clk);
    imem_ack = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h200;
    repeat (2) @(negedge clk);
    redirect = 1'b0;
    chk("perf_fetches", perf_fetches, 32'd10);
    chk("perf_flushes", perf_flushes, 32'd2);
`endif

    // ---- random run against queue model ----
    do_reset();
    m_q.delete();
    m_pc = 32'h0; m_out = 0; mem_busy = 0; mem_cnt = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      bit  pop, has_space;
      int  r;
      instr_ready = ($urandom_range(0, 9) < 7);
      redirect    = ($urandom_range(0, 19) == 0);
      r = int'($urandom_range(0, 3));
      redirect_pc = (r == 0) ? 32'hFFFF_FFFA : ($urandom & 32'hFFFF_FFFE);
      imem_ack = 1'b0;
      if (imem_req) begin
        if (!mem_busy) begin
          mem_busy = 1;
          mem_cnt  = int'($urandom_range(0, 3));
        end
        if (mem_cnt == 0) begin
          imem_ack = 1'b1;
          mem_busy = 0;
        end else mem_cnt--;
      end

      chk("rnd_req", {31'h0, imem_req}, {31'h0, (m_out != 0)});
      chk("rnd_addr", imem_addr, m_pc);
      chk("rnd_valid", {31'h0, instr_valid}, {31'h0, (m_q.size() > 0)});
      if (m_q.size() > 0) begin
        chk("rnd_pc", instr_pc, m_q[0].p);
        chk("rnd_instr", {16'h0, instr}, {16'h0, m_q[0].i});
      end

      pop       = (m_q.size() > 0) && instr_ready && !redirect;
      has_space = (m_q.size() < DEPTH);
      if (redirect) begin
        m_q.delete();
        m_out = (m_out == 0 || imem_ack) ? 1 : 2;
        m_pc  = redirect_pc;
      end else begin
        if (pop) void'(m_q.pop_front());
        if (m_out == 1 && imem_ack) begin
          m_q.push_back('{mem_word(m_pc), m_pc});
          m_pc  = m_pc + 32'd2;
          m_out = (m_q.size() < DEPTH) ? 1 : 0;
        end else if (m_out == 2 && imem_ack) begin
          m_out = 1;
        end else if (m_out == 0 && has_space) begin
          m_out = 1;
        end
      end
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
